// File: rtl/result_serializer.sv
// Snapshots the 23-bit compressor result on a capture strobe and streams it
// LSB first, followed by an even-parity bit, over a valid/ready handshake.
module result_serializer #(
  parameter int WIDTH = 23,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dst0,
  input  logic             dst1,
  input  logic             dst2,
  input  logic             dst3,
  input  logic             dst4,
  input  logic             dst5,
  input  logic             dst6,
  input  logic             dst7,
  input  logic             dst8,
  input  logic             dst9,
  input  logic             dst10,
  input  logic             dst11,
  input  logic             dst12,
  input  logic             dst13,
  input  logic             dst14,
  input  logic             dst15,
  input  logic             dst16,
  input  logic             dst17,
  input  logic             dst18,
  input  logic             dst19,
  input  logic             dst20,
  input  logic             dst21,
  input  logic             dst22,
  input  logic             capture,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             parity;
  logic [WIDTH-1:0] snap;
  logic             xfer;
  logic             load;
  logic             drop;

  assign snap = WIDTH'({dst22, dst21, dst20, dst19, dst18, dst17, dst16, dst15,
                        dst14, dst13, dst12, dst11, dst10, dst9, dst8, dst7,
                        dst6, dst5, dst4, dst3, dst2, dst1, dst0});

  assign xfer = ser_valid & ser_ready;

  // A capture is accepted when idle, or on the very edge that completes the
  // parity bit so back-to-back frames leave no gap; otherwise it is dropped.
  assign load = capture && ((state == IDLE) || (state == PAR && xfer));
  assign drop = capture && !load && (state != IDLE);

  assign busy    = (state != IDLE);
  assign ser_out = (state == DATA) ? shreg[0] : (state == PAR) ? parity : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      parity     <= 1'b0;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (load) begin
        state     <= DATA;
        shreg     <= snap;
        parity    <= ^snap;
        idx       <= '0;
        ser_valid <= 1'b1;
        ser_last  <= 1'b0;
      end else begin
        case (state)
          DATA: begin
            if (xfer) begin
              shreg <= shreg >> 1;
              if (idx == LAST_IDX) begin
                state    <= PAR;
                ser_last <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          PAR: begin
            if (xfer) begin
              state     <= IDLE;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
          end
        endcase
      end

      if (drop && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
